irq_window_gen: RTL and testbench

// - Multi-channel, runtime-programmable interrupt stimulus generator for CPU benches and SoC bring-up.
// - Free-running cycle counter. Each channel drives one active-low interrupt line (irq/nmi style) low over a programmed

---
 rtl/irq_window_gen.sv | 178 +++++++++++++++++
 tb/tb_irq_window_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_window_gen.sv
// irq_window_gen
//   Multi-channel interrupt stimulus generator. A free-running cycle counter
//   drives a set of per-channel window engines. Each channel pulls its
//   active-low interrupt line low across a programmed count window. A window
//   is either one-shot or repeats every `period` counts.
//
// Ports
//   clk_ph1      clock; all state updates on the rising edge
//   rst          asynchronous, active-low reset
//   run          1 = counter advances and channels evaluate; 0 = frozen
//   clear        synchronous clear of counter and channel states
//   cfg_we       channel configuration write strobe
//   cfg_ch       target channel of cfg_we; out-of-range indices are ignored
//   cfg_start    window start count (ws)
//   cfg_stop     window stop count (we)
//   cfg_period   repeat period, 0 = one-shot
//   ack          per-channel acknowledge (IRQ_ACK_EN builds only)
//   cycle_count  current counter value
//   int_n        registered active-low interrupt lines
//   busy         channel is in WAIT, ASSERT or HOLD
//
// Build option
//   IRQ_ACK_EN   adds the ack port. A window that reaches its stop count
//                without an ack holds its line low in HOLD until ack arrives.

module irq_window_gen #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8,
    parameter int CH_W     = 1
) (
    input  logic                clk_ph1,
    input  logic                rst,
    input  logic                run,
    input  logic                clear,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_start,
    input  logic [CNT_W-1:0]    cfg_stop,
    input  logic [CNT_W-1:0]    cfg_period,
`ifdef IRQ_ACK_EN
    input  logic [CHANNELS-1:0] ack,
`endif
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CHANNELS-1:0] int_n,
    output logic [CHANNELS-1:0] busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ASSERT,
        ST_DONE,
        ST_HOLD
    } state_t;

    state_t           state_q [CHANNELS];
    logic [CNT_W-1:0] ws_q    [CHANNELS];
    logic [CNT_W-1:0] we_q    [CHANNELS];
    logic [CNT_W-1:0] per_q   [CHANNELS];
`ifdef IRQ_ACK_EN
    // Set when ack released the line early; the window still runs to we.
    logic [CHANNELS-1:0] acked_q;
`endif

    // Free-running counter. Wrap-around is implicit in the CNT_W width.
    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values, independent of block order.
            cycle_count <= '0;
        end else if (clear) begin
            cycle_count <= '0;
        end else if (run) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end

    // Channel engines. The window compares use the pre-increment counter value,
    // so the line is low while cycle_count reads ws+1 .. we.
    // On release, adding the period to both ends reschedules the window.
    // With period 0 the addition is a no-op.
    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            int_n <= '1;
`ifdef IRQ_ACK_EN
            acked_q <= '0;
`endif
            for (int i = 0; i < CHANNELS; i++) begin
                // NOTE: the per-channel working registers are small arrays
                // that must read 0 after reset, so they get reset here too.
                state_q[i] <= ST_IDLE;
                ws_q[i]    <= '0;
                we_q[i]    <= '0;
                per_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (clear) begin
                    // Working window registers are kept across clear.
                    state_q[i] <= ST_IDLE;
                    int_n[i]   <= 1'b1;
`ifdef IRQ_ACK_EN
                    acked_q[i] <= 1'b0;
`endif
                end else if (cfg_we && int'(cfg_ch) == i) begin
                    // Also aborts an in-flight window (ASSERT/HOLD).
                    ws_q[i]    <= cfg_start;
                    we_q[i]    <= cfg_stop;
                    per_q[i]   <= cfg_period;
                    state_q[i] <= ST_WAIT;
                    int_n[i]   <= 1'b1;
`ifdef IRQ_ACK_EN
                    acked_q[i] <= 1'b0;
`endif
                end else if (run) begin
                    case (state_q[i])
                        ST_WAIT: begin
                            if (cycle_count == ws_q[i]) begin
                                if (ws_q[i] == we_q[i]) begin
                                    state_q[i] <= ST_DONE;
                                end else begin
                                    state_q[i] <= ST_ASSERT;
                                    int_n[i]   <= 1'b0;
                                end
                            end
                        end
                        ST_ASSERT: begin
`ifdef IRQ_ACK_EN
                            if (cycle_count == we_q[i]) begin
                                if (acked_q[i] || ack[i]) begin
                                    int_n[i]   <= 1'b1;
                                    acked_q[i] <= 1'b0;
                                    ws_q[i]    <= ws_q[i] + per_q[i];
                                    we_q[i]    <= we_q[i] + per_q[i];
                                    state_q[i] <= (per_q[i] != '0) ? ST_WAIT : ST_DONE;
                                end else begin
                                    state_q[i] <= ST_HOLD;
                                end
                            end else if (ack[i]) begin
                                int_n[i]   <= 1'b1;
                                acked_q[i] <= 1'b1;
                            end
`else
                            if (cycle_count == we_q[i]) begin
                                int_n[i]   <= 1'b1;
                                ws_q[i]    <= ws_q[i] + per_q[i];
                                we_q[i]    <= we_q[i] + per_q[i];
                                state_q[i] <= (per_q[i] != '0) ? ST_WAIT : ST_DONE;
                            end
`endif
                        end
`ifdef IRQ_ACK_EN
                        ST_HOLD: begin
                            // ack is only sampled while run=1, like all evaluation.
                            if (ack[i]) begin
                                int_n[i]   <= 1'b1;
                                ws_q[i]    <= ws_q[i] + per_q[i];
                                we_q[i]    <= we_q[i] + per_q[i];
                                state_q[i] <= (per_q[i] != '0) ? ST_WAIT : ST_DONE;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy[i] = (state_q[i] == ST_WAIT) || (state_q[i] == ST_ASSERT) ||
                      (state_q[i] == ST_HOLD);
        end
    end

endmodule

// File: tb/tb_irq_window_gen.sv
// Scoreboard bench for irq_window_gen. The stimulus pushes the expected
// {cycle_count, int_n, busy} for every change of int_n/busy it provokes.
// A monitor pops an entry on each observed change and compares it.
module tb_irq_window_gen;

    logic       clk_ph1 = 1'b0;
    logic       rst;
    logic       run, clear, cfg_we;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_start, cfg_stop, cfg_period;
`ifdef IRQ_ACK_EN
    logic [1:0] ack;
`endif
    logic [7:0] cycle_count;
    logic [1:0] int_n, busy;

    irq_window_gen #(.CHANNELS(2), .CNT_W(8), .CH_W(1)) dut (
        .clk_ph1     (clk_ph1),
        .rst         (rst),
        .run         (run),
        .clear       (clear),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_start   (cfg_start),
        .cfg_stop    (cfg_stop),
        .cfg_period  (cfg_period),
`ifdef IRQ_ACK_EN
        .ack         (ack),
`endif
        .cycle_count (cycle_count),
        .int_n       (int_n),
        .busy        (busy)
    );

    always #5 clk_ph1 = ~clk_ph1;

    typedef struct {
        string      name;
        logic [7:0] cnt;
        logic [1:0] int_n;
        logic [1:0] busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic expect_ev(input string name, input int cnt, input logic [1:0] n, input logic [1:0] b);
        exp_t e;
        e.name  = name;
        e.cnt   = cnt[7:0];
        e.int_n = n;
        e.busy  = b;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_ph1);
            #1;
        end
    endtask

    task automatic cfg(input logic [0:0] ch, input logic [7:0] s, input logic [7:0] e, input logic [7:0] p);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_start  = s;
        cfg_stop   = e;
        cfg_period = p;
    endtask

    // Monitor: every change of int_n/busy must match the next queued expectation.
    initial begin : monitor
        logic [3:0] prev, cur;
        exp_t e;
        @(posedge rst);
        prev = {int_n, busy};
        forever begin
            @(negedge clk_ph1);
            cur = {int_n, busy};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_change: got cnt=%0d int_n=%b busy=%b, expected no change",
                             cycle_count, int_n, busy);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, {20'd0, cycle_count, int_n, busy}, {20'd0, e.cnt, e.int_n, e.busy});
                end
                prev = cur;
            end
        end
    end

    initial begin : stimulus
        rst = 1'b0; run = 1'b0; clear = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_start = '0; cfg_stop = '0; cfg_period = '0;
`ifdef IRQ_ACK_EN
        ack = '0;
`endif
        #300;
        check("rst_count", {24'd0, cycle_count}, 32'd0);
        check("rst_int_n", {30'd0, int_n}, 32'h3);
        check("rst_busy",  {30'd0, busy},  32'h0);
        #302 rst = 1'b1;
        tick(1);

        // One-shot windows on both channels, overlapping.
        cfg(0, 8'd5, 8'd20, 8'd0);  expect_ev("s1_cfg0", 0, 2'b11, 2'b01); tick(1);
        cfg(1, 8'd10, 8'd20, 8'd0); expect_ev("s1_cfg1", 0, 2'b11, 2'b11); tick(1);
        cfg_we = 1'b0; run = 1'b1;
        expect_ev("s1_ch0_low",  6,  2'b10, 2'b11);
        expect_ev("s1_ch1_low",  11, 2'b00, 2'b11);
        expect_ev("s1_release",  21, 2'b11, 2'b00);
        tick(25); run = 1'b0;

        // Periodic window crossing the counter wrap: 250..252, 2..4, 10..12.
        clear = 1'b1; tick(1); clear = 1'b0;
        cfg(0, 8'd250, 8'd252, 8'd8); expect_ev("s3_cfg", 0, 2'b11, 2'b01); tick(1);
        cfg_we = 1'b0; run = 1'b1;
        expect_ev("s3_low_a",  251, 2'b10, 2'b01);
        expect_ev("s3_high_a", 253, 2'b11, 2'b01);
        expect_ev("s3_low_b",  3,   2'b10, 2'b01);
        expect_ev("s3_high_b", 5,   2'b11, 2'b01);
        expect_ev("s3_low_c",  11,  2'b10, 2'b01);
        expect_ev("s3_high_c", 13,  2'b11, 2'b01);
        tick(270); run = 1'b0;
        clear = 1'b1; expect_ev("s3_clear", 0, 2'b11, 2'b00); tick(1); clear = 1'b0;

        // Window spanning the wrap, then an empty window.
        cfg(0, 8'd250, 8'd4, 8'd0); expect_ev("s4_cfg", 0, 2'b11, 2'b01); tick(1);
        cfg_we = 1'b0; run = 1'b1;
        expect_ev("s4_low",  251, 2'b10, 2'b01);
        expect_ev("s4_high", 5,   2'b11, 2'b00);
        tick(262); run = 1'b0;
        cfg(0, 8'd7, 8'd7, 8'd0); expect_ev("empty_cfg", 6, 2'b11, 2'b01); tick(1);
        cfg_we = 1'b0; run = 1'b1;
        expect_ev("empty_done", 8, 2'b11, 2'b00);
        tick(3); run = 1'b0;

        // Reconfiguring an asserted channel aborts and reloads it.
        clear = 1'b1; tick(1); clear = 1'b0;
        cfg(0, 8'd2, 8'd10, 8'd0); expect_ev("abort_cfg", 0, 2'b11, 2'b01); tick(1);
        cfg_we = 1'b0; run = 1'b1;
        expect_ev("abort_low", 3, 2'b10, 2'b01);
        tick(5);
        cfg(0, 8'd8, 8'd9, 8'd0); expect_ev("abort_reload", 6, 2'b11, 2'b01); tick(1);
        cfg_we = 1'b0;
        expect_ev("abort_low2",  9,  2'b10, 2'b01);
        expect_ev("abort_high2", 10, 2'b11, 2'b00);
        tick(5); run = 1'b0;

        // Asynchronous reset mid-window.
        clear = 1'b1; tick(1); clear = 1'b0;
        cfg(0, 8'd2, 8'd20, 8'd0); expect_ev("rst_cfg", 0, 2'b11, 2'b01); tick(1);
        cfg_we = 1'b0; run = 1'b1;
        expect_ev("rst_low", 3, 2'b10, 2'b01);
        tick(6);
        expect_ev("rst_mid", 0, 2'b11, 2'b00);
        rst = 1'b0; #1;
        check("rst_mid_count", {24'd0, cycle_count}, 32'd0);
        check("rst_mid_int_n", {30'd0, int_n}, 32'h3);
        run = 1'b0; tick(2); rst = 1'b1; tick(1);

        // Synchronous clear mid-window acts only at the next edge.
        cfg(1, 8'd1, 8'd30, 8'd0); expect_ev("clr_cfg", 0, 2'b11, 2'b10); tick(1);
        cfg_we = 1'b0; run = 1'b1;
        expect_ev("clr_low", 2, 2'b01, 2'b10);
        tick(5);
        clear = 1'b1;
        check("clear_pending", {30'd0, int_n}, 32'h1);
        expect_ev("clear_mid", 0, 2'b11, 2'b00);
        tick(1); clear = 1'b0;

        // cfg_we together with clear leaves the channel idle.
        tick(3);
        cfg(0, 8'd0, 8'd3, 8'd0); clear = 1'b1; tick(1);
        cfg_we = 1'b0; clear = 1'b0;
        tick(6);
        check("cfg_clear_busy",  {30'd0, busy},  32'h0);
        check("cfg_clear_int_n", {30'd0, int_n}, 32'h3);
        run = 1'b0;

`ifdef IRQ_ACK_EN
        // Without ack the line is held past we; ack sampled at count 12 releases it.
        clear = 1'b1; tick(1); clear = 1'b0;
        cfg(0, 8'd5, 8'd8, 8'd0); expect_ev("ack_cfg", 0, 2'b11, 2'b01); tick(1);
        cfg_we = 1'b0; run = 1'b1;
        expect_ev("ack_low", 6, 2'b10, 2'b01);
        tick(12);
        check("ack_hold", {30'd0, int_n}, 32'h2);
        ack = 2'b01; expect_ev("ack_release", 13, 2'b11, 2'b00); tick(1);
        ack = 2'b00; tick(2); run = 1'b0;
`endif

        tick(3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
